// File: rtl/params.sv
// params: shared constants and types for the video pipeline.
// Colours are packed [2]=R, [1]=G, [0]=B.
package params;

  localparam int HRES       = 640;
  localparam int MAX_LAYERS = 8;
  localparam int IDX_W      = $clog2(MAX_LAYERS);

  typedef logic [2:0][7:0] COLOR_T;

  localparam COLOR_T BG_COLOR    = 24'h102040;
  localparam COLOR_T ENEMY_COLOR = 24'hFF2020;

  typedef struct packed {
    logic                   de;
    logic                   hsync;
    logic                   vsync;
    logic                   any;
    logic [IDX_W-1:0]       idx;
    COLOR_T [MAX_LAYERS-1:0] px;
  } s1_t;

endpackage

// File: rtl/priority_select.sv
// priority_select: lowest-index active layer encoder.
// Layer 0 wins; any is set when at least one layer is active.
module priority_select
  import params::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     active,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) idx = IDX_W'(i);
    end
  end

  assign any = |active;

endmodule

// File: rtl/pixel_compositor.sv
// pixel_compositor: 2-stage sprite layer merge, optional
// per-frame collision mask (COMPOSITOR_COLLISION_EN).
module pixel_compositor
  import params::*;
#(
  parameter int     NUM_LAYERS = 4,
  parameter COLOR_T BG_COLOR   = params::BG_COLOR
) (
  input  logic                             pixel_clk,
  input  logic                             rst_n,
  input  logic                             fsync,
  input  logic                             de_in,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic [NUM_LAYERS-1:0]            layer_active,
  input  logic [NUM_LAYERS-1:0][2:0][7:0]  layer_pixel,
  output logic [2:0][7:0]                  pixel_out,
  output logic                             de_out,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic [NUM_LAYERS-1:0]            collision_mask,
  output logic                             collision_valid
);

  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  s1_t              s1_d;
  s1_t              s1_q;
  COLOR_T           px_sel;

  priority_select #(
    .N(NUM_LAYERS)
  ) u_sel (
    .active(layer_active),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.de    = de_in;
    s1_d.hsync = hsync_in;
    s1_d.vsync = vsync_in;
    s1_d.any   = sel_any;
    s1_d.idx   = sel_idx;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      s1_d.px[i] = layer_pixel[i];
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

  // Blanking forces black even when sprites are active.
  always_comb begin
    px_sel = '0;
    unique case (1'b1)
      !s1_q.de:               px_sel = '0;
      s1_q.de && s1_q.any:    px_sel = s1_q.px[s1_q.idx];
      default:                px_sel = BG_COLOR;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      pixel_out <= px_sel;
      de_out    <= s1_q.de;
      hsync_out <= s1_q.hsync;
      vsync_out <= s1_q.vsync;
    end
  end

`ifdef COMPOSITOR_COLLISION_EN
  logic [NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS-1:0] coll;
  logic                  multi;

  assign multi = |(layer_active & (layer_active - NUM_LAYERS'(1)));
  assign coll  = (de_in && multi) ? layer_active : '0;

  // The fsync pixel belongs to the new frame.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc             <= '0;
      collision_mask  <= '0;
      collision_valid <= 1'b0;
    end else begin
      collision_valid <= fsync;
      if (fsync) begin
        collision_mask <= acc;
        acc            <= coll;
      end else begin
        acc <= acc | coll;
      end
    end
  end
`else
  logic unused_fsync;
  assign unused_fsync    = fsync;
  assign collision_mask  = '0;
  assign collision_valid = 1'b0;
`endif

endmodule

// File: doc/pixel_compositor.md
PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 4, meaning number of sprite layers merged (2..8).
REQ-002 Parameter BG_COLOR, default params::BG_COLOR, meaning 24-bit RGB shown where no layer is active.
REQ-003 pixel_clk  input  1  pixel clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 fsync  input  1  one-cycle frame-boundary pulse, same timing as the sprites' fsync.
REQ-006 de_in / hsync_in / vsync_in  input  1 each  display enable and syncs, aligned to the layer inputs.
REQ-007 layer_active  input  NUM_LAYERS  per-layer active flag.
REQ-008 layer_pixel  input  [NUM_LAYERS][3][8]  per-layer colour, index 2=R, 1=G, 0=B.
REQ-009 pixel_out  output  [3][8]  composited colour.
REQ-010 de_out / hsync_out / vsync_out  output  1 each  inputs delayed to match pixel_out.
REQ-011 collision_mask  output  NUM_LAYERS  layers that overlapped another layer during the previous frame.
REQ-012 collision_valid  output  1  one-cycle pulse when collision_mask updates.

Function
REQ-013 Two-stage pipeline: the pixel_out, de_out, hsync_out and vsync_out values for an input sample shall appear exactly 2 cycles after it.
REQ-014 Stage 1 shall register de/syncs and the index of the lowest-numbered active layer plus an any-active flag; stage 2 shall register the selected colour.
REQ-015 Priority: layer 0 highest; among simultaneous active layers only the lowest index is visible.
REQ-016 de_in=0 -> pixel_out = 0x000000 regardless of layer_active.
REQ-017 de_in=1, no layer active -> pixel_out = BG_COLOR.
REQ-018 Collision: a pixel with de_in=1 and 2 or more layers active shall OR those layers' bits into a frame accumulator.
REQ-019 On fsync: collision_mask <= accumulator (including any collision on the fsync cycle itself is excluded; that pixel goes to the new frame), accumulator cleared then loaded with that cycle's collision bits, collision_valid=1 for exactly one cycle, 1 cycle after fsync.
REQ-020 collision_mask shall hold its value between fsync pulses.
REQ-021 Back-to-back fsync on consecutive cycles: each shall publish and pulse; the second publishes only the first cycle's collisions.
REQ-022 No backpressure; one pixel per cycle, every cycle.

Reset
REQ-023 While rst_n=0: pixel_out=0, de_out=0, hsync_out=0, vsync_out=0, collision_mask=0, collision_valid=0, accumulator=0, all pipeline registers cleared.
REQ-024 Reset asserted mid-frame shall discard in-flight pixels; after release, outputs shall be valid from the third clock edge and the first collision_valid shall come only after the next fsync.

Configuration
REQ-025 Macro COMPOSITOR_COLLISION_EN: defined -> REQ-018..REQ-021 implemented.
REQ-026 Not defined -> no accumulator logic; collision_mask tied 0, collision_valid tied 0; pixel path and latency unchanged.

Structure
REQ-027 params package shall hold BG_COLOR, COLOR_T (3x8 array typedef) and MAX_LAYERS; existing ENEMY_COLOR/HRES constants stay there.
REQ-028 One sub-module, priority_select, shall provide the combinational lowest-index-active encoder (index + any-active flag) for NUM_LAYERS inputs.

Verification
REQ-029 de_in=1, only layer 2 active with 0x00FF00 -> pixel_out=0x00FF00 2 cycles later, de_out=1 on the same cycle.
REQ-030 Layers 1 and 3 active (0xFF0000, 0x0000FF) -> pixel_out=0xFF0000; collision_mask=4'b1010 with collision_valid pulse 1 cycle after the next fsync.
REQ-031 de_in=0 with all layers active -> pixel_out=0x000000; no collision recorded (mask 0 after fsync).
REQ-032 Frame with no overlaps after a colliding frame -> next fsync publishes mask 0; mask held constant between fsyncs.
REQ-033 rst_n pulsed low mid-frame during a collision -> all outputs 0 asynchronously; mask after the following fsync reflects only post-reset collisions.
REQ-034 Build without COMPOSITOR_COLLISION_EN, rerun REQ-030 stimulus -> pixel_out identical, collision_valid never 1.
